key_conditioner: RTL and testbench

Input-side conditioner for the lab-board push-buttons: synchronizes, debounces and edge-detects NUM_KEYS active-low raw key inputs. Produces a clean level plus single-cycle press/release strobes per key, in the `clk` domain. Counters, shift registers and display logic consume these as `count_enable`/`clear` style qualifiers. The block replaces using raw key lines as clocks.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_debounce.sv | 141 ++++++++++++++
 rtl/key_conditioner.sv | 36 +++
 tb/tb_key_conditioner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_t;

    // Defaults assume a 50 MHz clock: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat rate.
    localparam int DEFAULT_NUM_KEYS        = 3;
    localparam int DEFAULT_CNT_BITS        = 20;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, debounce FSM and registered press/release strobes.
// Define KEY_AUTOREPEAT_EN to emit repeated press strobes while the key stays held.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_BITS        = DEFAULT_CNT_BITS,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic n_rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    // Bad timing parameters are caught at elaboration rather than producing a silent mis-count.
    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_BITS) - 1)) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES out of range for CNT_BITS");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_debounce: REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end

`ifdef KEY_AUTOREPEAT_EN
    // The repeat intervals are far longer than the debounce window, so the shared counter widens to fit them.
    localparam int REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_BITS = $clog2(REP_MAX + 1);
    localparam int CW       = (CNT_BITS > REP_BITS) ? CNT_BITS : REP_BITS;
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
`else
    localparam int CW = CNT_BITS;
`endif
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          key_sync;
    key_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt, press_nxt, release_nxt;
`ifdef KEY_AUTOREPEAT_EN
    logic          rep_phase, rep_phase_nxt;
`endif

    assign key_sync = sync_q[1];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q      <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_phase   <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], key_n};
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
`ifdef KEY_AUTOREPEAT_EN
            rep_phase   <= rep_phase_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        level_nxt     = key_level;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_phase_nxt = rep_phase;
`endif
        unique case (state)
            IDLE: begin
                if (!key_sync) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (key_sync) begin
                    state_nxt = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nxt     = HELD;
                    level_nxt     = 1'b1;
                    press_nxt     = 1'b1;
                    cnt_nxt       = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rep_phase_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (key_sync) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = '0;
`ifdef KEY_AUTOREPEAT_EN
                // rep_phase selects the long initial wait versus the short repeat period.
                end else if ((!rep_phase && cnt == DELAY_LAST) || (rep_phase && cnt == PERIOD_LAST)) begin
                    press_nxt     = 1'b1;
                    cnt_nxt       = '0;
                    rep_phase_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
`endif
                end
            end
            REL_CHK: begin
                if (!key_sync) begin
                    state_nxt     = HELD;
                    cnt_nxt       = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rep_phase_nxt = 1'b0;
`endif
                end else if (cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS active-low push-buttons into clean levels and press/release strobes.
// Autorepeat of press strobes is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_BITS        = DEFAULT_CNT_BITS,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_BITS       (CNT_BITS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_key (
            .clk        (clk),
            .n_rst      (n_rst),
            .key_n      (key_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a 4-cycle debounce window.
// Under KEY_AUTOREPEAT_EN it also expects repeat strobes at 10/3-cycle spacing.
module tb_key_conditioner;

    logic       clk;
    logic       n_rst;
    logic [2:0] key_n;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;

    int compared;
    int mismatched;

    key_conditioner #(
        .NUM_KEYS       (3),
        .DEBOUNCE_CYCLES(4),
        .CNT_BITS       (20),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 unit past the last edge for sampling and driving.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        key_n = 3'b111;
        step(2);
        compared++;
        if (key_level !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_level actual=%b required=000", key_level); end
        compared++;
        if (key_press !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_press actual=%b required=000", key_press); end
        compared++;
        if (key_release !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_release actual=%b required=000", key_release); end
        n_rst = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step(1);
            compared++;
            if ({key_level, key_press, key_release} !== 9'd0) begin
                mismatched++;
                $display("[TB] FAIL idle_after_reset e=%0d actual=%b required=0", e, {key_level, key_press, key_release});
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] exp_press, exp_level, exp_rel;
        key_n = 3'b110;
        for (int e = 0; e < 10; e++) begin
            step(1);
            exp_press = (e == 6) ? 3'b001 : 3'b000;
            exp_level = (e >= 6) ? 3'b001 : 3'b000;
            compared++;
            if (key_press !== exp_press) begin mismatched++; $display("[TB] FAIL clean_press e=%0d actual=%b required=%b", e, key_press, exp_press); end
            compared++;
            if (key_level !== exp_level) begin mismatched++; $display("[TB] FAIL clean_level e=%0d actual=%b required=%b", e, key_level, exp_level); end
        end
        key_n = 3'b111;
        for (int e = 0; e < 10; e++) begin
            step(1);
            exp_rel   = (e == 6) ? 3'b001 : 3'b000;
            exp_level = (e >= 6) ? 3'b000 : 3'b001;
            compared++;
            if (key_release !== exp_rel) begin mismatched++; $display("[TB] FAIL clean_release e=%0d actual=%b required=%b", e, key_release, exp_rel); end
            compared++;
            if (key_level !== exp_level) begin mismatched++; $display("[TB] FAIL clean_rel_level e=%0d actual=%b required=%b", e, key_level, exp_level); end
            compared++;
            if (key_press !== 3'b000) begin mismatched++; $display("[TB] FAIL clean_no_press e=%0d actual=%b required=000", e, key_press); end
        end
    endtask

    task automatic test_bounce_reject();
        logic [2:0] exp_press, exp_level, exp_rel;
        for (int e = 0; e < 12; e++) begin
            key_n[1] = (e < 3) ? 1'b0 : 1'b1;
            step(1);
            compared++;
            if ({key_level, key_press, key_release} !== 9'd0) begin
                mismatched++;
                $display("[TB] FAIL bounce_reject e=%0d actual=%b required=0", e, {key_level, key_press, key_release});
            end
        end
        for (int e = 0; e < 18; e++) begin
            key_n[1] = (e < 8) ? 1'b0 : 1'b1;
            step(1);
            exp_press = (e == 6) ? 3'b010 : 3'b000;
            exp_rel   = (e == 14) ? 3'b010 : 3'b000;
            exp_level = (e >= 6 && e < 14) ? 3'b010 : 3'b000;
            compared++;
            if (key_press !== exp_press) begin mismatched++; $display("[TB] FAIL long_press e=%0d actual=%b required=%b", e, key_press, exp_press); end
            compared++;
            if (key_release !== exp_rel) begin mismatched++; $display("[TB] FAIL long_release e=%0d actual=%b required=%b", e, key_release, exp_rel); end
            compared++;
            if (key_level !== exp_level) begin mismatched++; $display("[TB] FAIL long_level e=%0d actual=%b required=%b", e, key_level, exp_level); end
        end
    endtask

    task automatic test_release_bounce();
        logic [2:0] exp_level, exp_rel;
        key_n[2] = 1'b0;
        step(8);
        compared++;
        if (key_level !== 3'b100) begin mismatched++; $display("[TB] FAIL relb_held actual=%b required=100", key_level); end
        // Pattern 1,0,1,1,...: the final stable high is first sampled at e=2.
        for (int e = 0; e < 12; e++) begin
            key_n[2] = (e == 1) ? 1'b0 : 1'b1;
            step(1);
            exp_rel   = (e == 8) ? 3'b100 : 3'b000;
            exp_level = (e < 8) ? 3'b100 : 3'b000;
            compared++;
            if (key_release !== exp_rel) begin mismatched++; $display("[TB] FAIL relb_release e=%0d actual=%b required=%b", e, key_release, exp_rel); end
            compared++;
            if (key_level !== exp_level) begin mismatched++; $display("[TB] FAIL relb_level e=%0d actual=%b required=%b", e, key_level, exp_level); end
            compared++;
            if (key_press !== 3'b000) begin mismatched++; $display("[TB] FAIL relb_no_press e=%0d actual=%b required=000", e, key_press); end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_press, exp_rel;
        key_n = 3'b000;
        for (int e = 0; e < 9; e++) begin
            step(1);
            exp_press = (e == 6) ? 3'b111 : 3'b000;
            compared++;
            if (key_press !== exp_press) begin mismatched++; $display("[TB] FAIL simul_press e=%0d actual=%b required=%b", e, key_press, exp_press); end
        end
        key_n = 3'b111;
        for (int e = 0; e < 9; e++) begin
            step(1);
            exp_rel = (e == 6) ? 3'b111 : 3'b000;
            compared++;
            if (key_release !== exp_rel) begin mismatched++; $display("[TB] FAIL simul_release e=%0d actual=%b required=%b", e, key_release, exp_rel); end
        end
        compared++;
        if (key_level !== 3'b000) begin mismatched++; $display("[TB] FAIL simul_level actual=%b required=000", key_level); end
    endtask

    task automatic test_reset_mid_check();
        logic [2:0] exp_press;
        key_n = 3'b110;
        for (int e = 0; e < 4; e++) begin
            step(1);
            compared++;
            if (key_press !== 3'b000) begin mismatched++; $display("[TB] FAIL midrst_pre e=%0d actual=%b required=000", e, key_press); end
        end
        n_rst = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step(1);
            compared++;
            if ({key_level, key_press, key_release} !== 9'd0) begin
                mismatched++;
                $display("[TB] FAIL midrst_in_reset e=%0d actual=%b required=0", e, {key_level, key_press, key_release});
            end
        end
        n_rst = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step(1);
            exp_press = (e == 6) ? 3'b001 : 3'b000;
            compared++;
            if (key_press !== exp_press) begin mismatched++; $display("[TB] FAIL midrst_press e=%0d actual=%b required=%b", e, key_press, exp_press); end
            compared++;
            if (key_release !== 3'b000) begin mismatched++; $display("[TB] FAIL midrst_release e=%0d actual=%b required=000", e, key_release); end
        end
        key_n = 3'b111;
        step(10);
        compared++;
        if (key_level !== 3'b000) begin mismatched++; $display("[TB] FAIL midrst_final_level actual=%b required=000", key_level); end
    endtask

    task automatic test_autorepeat();
        logic exp_p;
        key_n = 3'b110;
        for (int e = 0; e < 27; e++) begin
            step(1);
`ifdef KEY_AUTOREPEAT_EN
            exp_p = (e == 6 || e == 16 || e == 19 || e == 22 || e == 25);
`else
            exp_p = (e == 6);
`endif
            compared++;
            if (key_press[0] !== exp_p) begin mismatched++; $display("[TB] FAIL repeat_press e=%0d actual=%b required=%b", e, key_press[0], exp_p); end
        end
        key_n = 3'b111;
        step(10);
        compared++;
        if (key_level !== 3'b000) begin mismatched++; $display("[TB] FAIL repeat_final_level actual=%b required=000", key_level); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        n_rst      = 1'b0;
        key_n      = 3'b111;
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid_check();
        test_autorepeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
